// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and counter width helper for the SPI output serializer.
package spi_pkg;
   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;
   function automatic int cnt_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/spi_out_ctrl_if.sv
// spi_out_ctrl_if: CPU-side word handshake plus the serial pin bundle.
interface spi_out_ctrl_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             busy;
   logic             done;
   logic             sclk;
   logic             sdata;
   logic             cs_n;
   modport master (output in_valid, in_data, input in_ready, busy, done, sclk, sdata, cs_n);
   modport slave  (input in_valid, in_data, output in_ready, busy, done, sclk, sdata, cs_n);
endinterface

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: parallel-load, shift-left register presenting its MSB.
module spi_shift_reg #(parameter int WIDTH = 16) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             msb
);
   logic [WIDTH-1:0] q;
   always_ff @(posedge clock or posedge reset)
      if (reset) q <= '0;
      else if (load) q <= din;
      else if (shift) q <= {q[WIDTH-2:0], 1'b0};
   assign msb = q[WIDTH-1];
endmodule

// File: rtl/spi_out_ctrl.sv
// spi_out_ctrl: serializes CPU words MSB-first onto sclk/sdata/cs_n with a one-word holding register.
module spi_out_ctrl import spi_pkg::*; #(
   parameter int WIDTH  = 16,
   parameter int DIV    = 4,
   parameter int CS_GAP = 2
) (
   input logic           clock,
   input logic           reset,
   spi_out_ctrl_if.slave bus
);
   localparam int PW = cnt_w(DIV > CS_GAP ? DIV : CS_GAP);
   localparam int BW = $clog2(WIDTH + 1);
   state_t           state, state_n;
   logic [PW-1:0]    phase;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH-1:0] hold;
   logic             hold_valid, phase_end, load, shift, msb, active;
   assign phase_end = phase == PW'(state == GAP ? CS_GAP - 1 : DIV - 1);
   assign load      = hold_valid && (state == IDLE || (state == GAP && phase_end));
   assign shift     = state == HIGH && phase_end;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = hold_valid ? SETUP : IDLE;
         SETUP:   state_n = phase_end ? HIGH : SETUP;
         HIGH:    state_n = phase_end ? LOW : HIGH;
         LOW:     state_n = phase_end ? (bit_cnt == BW'(WIDTH) ? GAP : HIGH) : LOW;
         GAP:     state_n = phase_end ? (hold_valid ? SETUP : IDLE) : GAP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state      <= IDLE;
         phase      <= '0;
         bit_cnt    <= '0;
         hold       <= '0;
         hold_valid <= 1'b0;
      end else begin
         state   <= state_n;
         phase   <= (state_n != state || state == IDLE) ? '0 : phase + 1'b1;
         bit_cnt <= load ? '0 : bit_cnt + BW'(shift);
         // a load always frees the slot; in_ready is low that cycle so no accept can collide
         if (load) hold_valid <= 1'b0;
         else if (bus.in_valid && !hold_valid) begin
            hold_valid <= 1'b1;
            hold       <= bus.in_data;
         end
      end
   spi_shift_reg #(.WIDTH(WIDTH)) u_shift (
      .clock(clock), .reset(reset), .load(load), .shift(shift), .din(hold), .msb(msb)
   );
   assign active       = state == SETUP || state == HIGH || state == LOW;
   assign bus.in_ready = !hold_valid;
   assign bus.busy     = state != IDLE;
   assign bus.done     = state == GAP && phase == '0;
   assign bus.sclk     = state == HIGH;
   assign bus.sdata    = active && msb;
   assign bus.cs_n     = !active;
endmodule

// File: tb/tb_spi_out_ctrl.sv
// tb_spi_out_ctrl: directed vectors and corner-case sequences for the SPI output serializer.
module tb_spi_out_ctrl;
   import spi_pkg::*;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   spi_out_ctrl_if #(.WIDTH(16)) bus ();
   spi_out_ctrl_if #(.WIDTH(2))  sbus ();
   spi_out_ctrl #(.WIDTH(16), .DIV(4), .CS_GAP(2)) dut   (.clock(clock), .reset(reset), .bus(bus.slave));
   spi_out_ctrl #(.WIDTH(2),  .DIV(1), .CS_GAP(2)) dut_s (.clock(clock), .reset(reset), .bus(sbus.slave));

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return i < q.size() ? q[i] : -1;
   endfunction

   // line monitor on the default-parameter instance
   logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_sdata = 1'b0;
   logic [15:0] shreg = '0;
   int nbits = 0, cs_cnt = 0, gap_cnt = 0, done_cnt = 0, cs_falls = 0, stab_err = 0, done_mis = 0;
   int rx_q[$], len_q[$], nb_q[$], gap_q[$];

   always @(negedge clock)
      if (reset) begin
         prev_cs   <= 1'b1;
         prev_sclk <= 1'b0;
         nbits     <= 0;
      end else begin
         prev_cs    <= bus.cs_n;
         prev_sclk  <= bus.sclk;
         prev_sdata <= bus.sdata;
         if (bus.done) done_cnt <= done_cnt + 1;
         if (bus.done && !(bus.cs_n && !prev_cs)) done_mis <= done_mis + 1;
         if (bus.sclk && prev_sclk && bus.sdata != prev_sdata) stab_err <= stab_err + 1;
         if (!bus.cs_n && prev_cs) begin
            cs_falls <= cs_falls + 1;
            cs_cnt   <= 1;
            nbits    <= 0;
            gap_q.push_back(gap_cnt);
         end else if (!bus.cs_n) cs_cnt <= cs_cnt + 1;
         if (bus.cs_n && !prev_cs) begin
            rx_q.push_back(int'(shreg));
            len_q.push_back(cs_cnt);
            nb_q.push_back(nbits);
            gap_cnt <= 1;
         end else if (bus.cs_n) gap_cnt <= gap_cnt + 1;
         if (bus.sclk && !prev_sclk) begin
            shreg <= {shreg[14:0], bus.sdata};
            nbits <= nbits + 1;
         end
      end

   task automatic clear_q();
      rx_q.delete();
      len_q.delete();
      nb_q.delete();
      gap_q.delete();
   endtask

   task automatic send_big(input logic [15:0] w);
      for (int i = 0; i < 400 && !bus.in_ready; i++) begin
         @(posedge clock);
         #1;
      end
      if (!bus.in_ready) check("send_ready_timeout", 0, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_words(input int n);
      for (int i = 0; i < 2000 && rx_q.size() < n; i++) @(posedge clock);
      #1;
      check("rx_word_count", rx_q.size(), n);
   endtask

   typedef struct {
      logic [15:0] word;
      logic [15:0] exp_bits;
      int          exp_len;
   } vec_t;
   vec_t vecs[4];

   initial begin
      int d0, f0, nb_at_rst;
      logic [6:0] v_cs, v_sclk, v_sdata, v_done;
      vecs[0] = '{16'hA5C3, 16'b1010010111000011, 132};
      vecs[1] = '{16'h0000, 16'b0000000000000000, 132};
      vecs[2] = '{16'hFFFF, 16'b1111111111111111, 132};
      vecs[3] = '{16'h3C01, 16'b0011110000000001, 132};
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      sbus.in_valid = 1'b0;
      sbus.in_data  = '0;

      repeat (3) @(posedge clock);
      #1;
      check("rst_cs_n", int'(bus.cs_n), 1);
      check("rst_sclk", int'(bus.sclk), 0);
      check("rst_sdata", int'(bus.sdata), 0);
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      reset = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      check("idle_cs_falls", cs_falls, 0);
      check("idle_done", done_cnt, 0);
      check("idle_busy", int'(bus.busy), 0);

      foreach (vecs[k]) begin
         clear_q();
         d0 = done_cnt;
         send_big(vecs[k].word);
         wait_words(1);
         check($sformatf("vec%0d_data", k), qget(rx_q, 0), int'(vecs[k].exp_bits));
         check($sformatf("vec%0d_nbits", k), qget(nb_q, 0), 16);
         check($sformatf("vec%0d_cs_len", k), qget(len_q, 0), vecs[k].exp_len);
         repeat (4) @(posedge clock);
         #1;
         check($sformatf("vec%0d_done_pulses", k), done_cnt - d0, 1);
      end

      // back-to-back words plus a third held off by backpressure
      clear_q();
      d0 = done_cnt;
      send_big(16'h8001);
      check("b2b_ready_after_accept", int'(bus.in_ready), 0);
      check("b2b_busy_before_setup", int'(bus.busy), 0);
      @(posedge clock);
      #1;
      check("b2b_ready_after_load", int'(bus.in_ready), 1);
      check("b2b_busy_setup", int'(bus.busy), 1);
      check("b2b_cs_n_setup", int'(bus.cs_n), 0);
      send_big(16'h7FFE);
      check("b2b_ready_hold_full", int'(bus.in_ready), 0);
      repeat (50) @(posedge clock);
      #1;
      check("backpressure_ready", int'(bus.in_ready), 0);
      send_big(16'h1234);
      wait_words(3);
      check("b2b_word0", qget(rx_q, 0), 16'h8001);
      check("b2b_word1", qget(rx_q, 1), 16'h7FFE);
      check("b2b_word2", qget(rx_q, 2), 16'h1234);
      check("b2b_len0", qget(len_q, 0), 132);
      check("b2b_len2", qget(len_q, 2), 132);
      check("b2b_gap1", qget(gap_q, 1), 2);
      check("b2b_gap2", qget(gap_q, 2), 2);
      repeat (4) @(posedge clock);
      #1;
      check("b2b_done_pulses", done_cnt - d0, 3);

      // DIV=1, WIDTH=2 instance, word 2'b10: IDLE, SETUP, HIGH, LOW, HIGH, LOW, GAP
      check("small_ready", int'(sbus.in_ready), 1);
      sbus.in_valid = 1'b1;
      sbus.in_data  = 2'b10;
      @(posedge clock);
      #1;
      sbus.in_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         v_cs[6-i]    = sbus.cs_n;
         v_sclk[6-i]  = sbus.sclk;
         v_sdata[6-i] = sbus.sdata;
         v_done[6-i]  = sbus.done;
      end
      @(posedge clock);
      #1;
      check("small_cs_n", int'(v_cs), 7'b1000001);
      check("small_sclk", int'(v_sclk), 7'b0010100);
      check("small_sdata", int'(v_sdata), 7'b0110000);
      check("small_done", int'(v_done), 7'b0000001);

      // reset during bit 7 of 0xFFFF with 0x1234 queued
      clear_q();
      d0 = done_cnt;
      f0 = cs_falls;
      send_big(16'hFFFF);
      send_big(16'h1234);
      for (int i = 0; i < 400 && nbits < 8; i++) begin
         @(posedge clock);
         #1;
      end
      nb_at_rst = nbits;
      check("rst_mid_bit_index", nb_at_rst, 8);
      reset = 1'b1;
      #1;
      check("rst_mid_cs_n", int'(bus.cs_n), 1);
      check("rst_mid_sclk", int'(bus.sclk), 0);
      check("rst_mid_sdata", int'(bus.sdata), 0);
      check("rst_mid_busy", int'(bus.busy), 0);
      check("rst_mid_in_ready", int'(bus.in_ready), 1);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (400) @(posedge clock);
      #1;
      check("rst_mid_no_done", done_cnt - d0, 0);
      check("rst_mid_no_queued_tx", cs_falls - f0, 1);
      check("rst_mid_rx_empty", rx_q.size(), 0);
      check("rst_mid_idle_busy", int'(bus.busy), 0);

      check("sdata_stable_high", stab_err, 0);
      check("done_aligned_cs_rise", done_mis, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
